// File: rtl/goertzel_tone_gen.sv
// Block tone generator: 2**SIZE_POW2 samples of a bin-snapped sinusoid from a Goertzel resonator.
// Optional macro TONE_GEN_SAT_EN: saturate the output sample instead of two's-complement wrap.
module goertzel_tone_gen #(
    parameter real FREQ       = 457000.0,
    parameter real SAMP_RATE  = 2000000.0,
    parameter int  SIZE_POW2  = 10,
    parameter int  DW         = 16,
    parameter int  AMP        = 2**(DW-2),
    parameter int  COEFF_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 ready_i,
    output logic signed [DW-1:0] data_o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int  SW   = DW + 2;
    localparam int  PW   = SW + COEFF_BITS;
    localparam int  FRAC = COEFF_BITS - 3;
    localparam int  N    = 2**SIZE_POW2;
    localparam real PI   = 3.14159265358979323846;

    function automatic real sin_f(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int i = 1; i <= 20; i++) begin
            term = -term * x * x / (real'(2*i) * real'(2*i + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic real cos_f(input real x);
        real term;
        real sum;
        term = 1.0;
        sum  = 1.0;
        for (int i = 1; i <= 20; i++) begin
            term = -term * x * x / (real'(2*i - 1) * real'(2*i));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Tiny guard keeps exact lattice values (e.g. sin(pi/2)) from truncating one LSB low.
    function automatic int rtoi_g(input real x);
        return (x >= 0.0) ? $rtoi(x + 1.0e-9) : $rtoi(x - 1.0e-9);
    endfunction

    localparam int  K       = $rtoi(0.5 + real'(N) * FREQ / SAMP_RATE);
    localparam real W       = 2.0 * PI * real'(K) / real'(N);
    localparam real WR      = (W > PI) ? (W - 2.0 * PI) : W;
    localparam int  COEFF_I = rtoi_g(2.0 * cos_f(WR) * real'(2**FRAC));
    localparam int  SEED_I  = rtoi_g(real'(AMP) * sin_f(WR));

    localparam logic signed [PW-1:0] COEFF_X = PW'(COEFF_I);
    localparam logic signed [SW-1:0] SEED_X  = SW'(SEED_I);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic signed [SW-1:0]   cur_reg, cur_next;
    logic signed [SW-1:0]   prev_reg, prev_next;
    logic [SIZE_POW2-1:0]   cnt_reg, cnt_next;

    logic signed [PW-1:0]   cur_ext;
    logic signed [PW-1:0]   prod;
    logic signed [SW-1:0]   step;
    logic signed [DW-1:0]   sample;
    logic                   unused_bits;

    assign cur_ext     = PW'(cur_reg);
    assign prod        = COEFF_X * cur_ext;
    assign step        = $signed(prod[SW+FRAC-1:FRAC]) - prev_reg;
    assign unused_bits = ^{prod[PW-1:SW+FRAC], prod[FRAC-1:0]};

`ifdef TONE_GEN_SAT_EN
    localparam logic signed [SW-1:0] MAXV = SW'(2**(DW-1) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(2**(DW-1)));

    always_comb begin
        sample = cur_reg[DW-1:0];
        if (cur_reg > MAXV)
            sample = MAXV[DW-1:0];
        else if (cur_reg < MINV)
            sample = MINV[DW-1:0];
    end
`else
    always_comb begin
        sample = cur_reg[DW-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cur_reg   <= '0;
            prev_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            prev_reg  <= prev_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        prev_next  = prev_reg;
        cnt_next   = cnt_reg;
        valid_o    = 1'b0;
        done_o     = 1'b0;
        busy_o     = (state_reg != IDLE);
        data_o     = '0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    cur_next   = '0;
                    prev_next  = -SEED_X;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                valid_o = 1'b1;
                data_o  = sample;
                if (ready_i) begin
                    cur_next  = step;
                    prev_next = cur_reg;
                    cnt_next  = cnt_reg + SIZE_POW2'(1);
                    if (cnt_reg == SIZE_POW2'(N - 1))
                        state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_goertzel_tone_gen.sv
// Directed bench for goertzel_tone_gen: ideal-sinusoid model checked every valid cycle,
// plus literal sample, handshake, reset and spectral checks.
module tb_goertzel_tone_gen;
    localparam real PI  = 3.14159265358979323846;
    localparam real FA  = 500000.0;
    localparam real FS  = 2000000.0;
    localparam real FC  = 457000.0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start_a = 1'b0, ready_a = 1'b1;
    logic start_b = 1'b0, ready_b = 1'b1;
    logic start_c = 1'b0, ready_c = 1'b1;
    logic signed [15:0] data_a, data_b, data_c;
    logic valid_a, busy_a, done_a;
    logic valid_b, busy_b, done_b;
    logic valid_c, busy_c, done_c;

    goertzel_tone_gen #(.FREQ(FA), .SAMP_RATE(FS), .SIZE_POW2(4), .DW(16), .AMP(8192), .COEFF_BITS(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .ready_i(ready_a),
        .data_o(data_a), .valid_o(valid_a), .busy_o(busy_a), .done_o(done_a));

    goertzel_tone_gen #(.FREQ(FA), .SAMP_RATE(FS), .SIZE_POW2(4), .DW(16), .AMP(40000), .COEFF_BITS(24)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .ready_i(ready_b),
        .data_o(data_b), .valid_o(valid_b), .busy_o(busy_b), .done_o(done_b));

    goertzel_tone_gen dut_c (
        .clk(clk), .rst_n(rst_n), .start_i(start_c), .ready_i(ready_c),
        .data_o(data_c), .valid_o(valid_c), .busy_o(busy_c), .done_o(done_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_cond(input string name, input bit ok, input real act, input real req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %g, required %g", name, act, req);
        end
    endtask

    function automatic int round_r(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic int bin_of(input int pow2, input real f, input real fs);
        return $rtoi(0.5 + real'(1 << pow2) * f / fs);
    endfunction

    // Ideal sample: AMP*sin(w*n) at the snapped bin, rounded
    function automatic int ideal(input int amp, input int pow2, input real f, input real fs, input int n);
        real w;
        w = 2.0 * PI * real'(bin_of(pow2, f, fs)) / real'(1 << pow2);
        return round_r(real'(amp) * $sin(w * real'(n)));
    endfunction

    function automatic int to_out(input int v);
        logic signed [15:0] t;
`ifdef TONE_GEN_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        t = v[15:0];
        return int'(t);
`endif
    endfunction

    // Per-cycle compare process against the model
    int idx_a = 0, hs_a = 0, done_cnt_a = 0;
    int idx_b = 0, hs_b = 0, done_cnt_b = 0;
    int idx_c = 0;
    bit hold_a = 1'b0;
    logic signed [15:0] last_a = '0;
    int cap_a[16];
    int cap_b[16];
    int cap_c[1024];

    always @(negedge clk) begin
        if (!rst_n) begin
            idx_a = 0; idx_b = 0; idx_c = 0; hold_a = 1'b0;
        end else begin
            if (valid_a) begin
                check("a_sample", data_a, to_out(ideal(8192, 4, FA, FS, idx_a)));
                check("a_busy_in_run", busy_a, 1);
                if (hold_a) check("a_hold_stable", data_a, last_a);
                if (ready_a) begin
                    cap_a[idx_a] = data_a;
                    idx_a = (idx_a + 1) % 16;
                    hs_a++;
                end
            end
            hold_a = valid_a && !ready_a;
            last_a = data_a;
            if (done_a) begin
                done_cnt_a++;
                check("a_done_valid_low", valid_a, 0);
            end
            if (valid_b) begin
                check("b_sample", data_b, to_out(ideal(40000, 4, FA, FS, idx_b)));
                cap_b[idx_b] = data_b;
                idx_b = (idx_b + 1) % 16;
                hs_b++;
            end
            if (done_b) done_cnt_b++;
            if (valid_c && idx_c < 1024) begin
                cap_c[idx_c] = data_c;
                idx_c++;
            end
        end
    end

    task automatic wait_done(input int which, input int budget, output int cycles);
        bit seen;
        seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge clk);
            cycles++;
            case (which)
                0:       seen = done_a;
                1:       seen = done_b;
                default: seen = done_c;
            endcase
        end
        check($sformatf("done_seen_%0d", which), seen, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int h0, d0, cyc;
    bit seen;
    int pat[4] = '{1, 0, 0, 1};
    real pk, pk3, pm, re, im, re3, im3, ph, ph3, x, wk, rel;
    int kc;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", data_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        rst_n = 1'b1;
        tick();

        // T1: full-rate block
        h0 = hs_a; d0 = done_cnt_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t1_latency_valid", valid_a, 1);
        check("t1_latency_data", data_a, 0);
        wait_done(0, 40, cyc);
        check("t1_cycles_to_done", cyc, 17);
        tick();
        check("t1_busy_after", busy_a, 0);
        check("t1_done_one_cycle", done_a, 0);
        check("t1_handshakes", hs_a - h0, 16);
        check("t1_done_count", done_cnt_a - d0, 1);
        check("t1_y0", cap_a[0], 0);
        check("t1_y1", cap_a[1], 8192);
        check("t1_y2", cap_a[2], 0);
        check("t1_y3", cap_a[3], -8192);
        check("t1_y13", cap_a[13], 8192);

        // T2: ready toggling 1,0,0,1
        h0 = hs_a; d0 = done_cnt_a; seen = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            ready_a = pat[i % 4][0];
            @(negedge clk);
            if (done_a) seen = 1'b1;
            tick();
        end
        ready_a = 1'b1;
        check("t2_done_seen", seen, 1);
        check("t2_handshakes", hs_a - h0, 16);
        check("t2_done_count", done_cnt_a - d0, 1);

        // T3: overrange amplitude
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        wait_done(1, 40, cyc);
        tick();
        check("t3_y0", cap_b[0], 0);
`ifdef TONE_GEN_SAT_EN
        check("t3_y1", cap_b[1], 32767);
        check("t3_y3", cap_b[3], -32768);
`else
        check("t3_y1", cap_b[1], -25536);
        check("t3_y3", cap_b[3], 25536);
`endif
        check("t3_done_count", done_cnt_b, 1);

        // T4: asynchronous reset mid-block
        h0 = hs_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 50 && (hs_a - h0) < 5; i++) @(negedge clk);
        check("t4_reached_5", hs_a - h0, 5);
        @(posedge clk);
        #3;
        d0 = done_cnt_a;
        rst_n = 1'b0;
        #1;
        check("t4_async_data", data_a, 0);
        check("t4_async_valid", valid_a, 0);
        check("t4_async_busy", busy_a, 0);
        check("t4_async_done", done_a, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t4_no_done", done_cnt_a - d0, 0);
        check("t4_idle_busy", busy_a, 0);
        h0 = hs_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t4_restart_data", data_a, 0);
        check("t4_restart_valid", valid_a, 1);
        wait_done(0, 40, cyc);
        tick();
        check("t4_restart_handshakes", hs_a - h0, 16);

        // T5: start during RUN ignored
        h0 = hs_a; d0 = done_cnt_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done(0, 40, cyc);
        repeat (4) tick();
        check("t5_ignored_busy", busy_a, 0);
        check("t5_handshakes", hs_a - h0, 16);
        check("t5_done_count", done_cnt_a - d0, 1);

        // T5: start held high -> back-to-back with one idle cycle
        h0 = hs_a; d0 = done_cnt_a;
        start_a = 1'b1;
        tick();
        wait_done(0, 40, cyc);
        tick();
        check("t5_gap_idle", busy_a, 0);
        tick();
        check("t5_second_busy", busy_a, 1);
        check("t5_second_y0", data_a, 0);
        start_a = 1'b0;
        wait_done(0, 40, cyc);
        tick();
        check("t5_b2b_done_count", done_cnt_a - d0, 2);
        check("t5_b2b_handshakes", hs_a - h0, 32);

        // T6: loopback into a DFT power detector at bin K and K+3
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        wait_done(2, 1100, cyc);
        tick();
        check("t6_sample_count", idx_c, 1024);
        kc = bin_of(10, FC, FS);
        check("t6_bin", kc, 234);
        re = 0.0; im = 0.0; re3 = 0.0; im3 = 0.0; pm = 0.0;
        wk = 2.0 * PI * real'(kc) / 1024.0;
        for (int n = 0; n < 1024; n++) begin
            x   = real'(cap_c[n]);
            ph  = wk * real'(n);
            ph3 = 2.0 * PI * real'(kc + 3) * real'(n) / 1024.0;
            re  = re + x * $cos(ph);
            im  = im - x * $sin(ph);
            re3 = re3 + x * $cos(ph3);
            im3 = im3 - x * $sin(ph3);
        end
        pk  = re * re + im * im;
        pk3 = re3 * re3 + im3 * im3;
        // An ideal AMP-peak tone on bin K has |X|^2 = (AMP*N/2)^2
        pm  = (16384.0 * 512.0) * (16384.0 * 512.0);
        rel = (pk > pm) ? (pk - pm) / pm : (pm - pk) / pm;
        check_cond("t6_power_bin_k", rel <= 0.01, pk, pm);
        check_cond("t6_leak_bin_k3", pk3 <= pk * 1.0e-4, pk3, pk * 1.0e-4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
